// File: rtl/fifo_pkg.sv
// fifo_pkg: parameters and helpers shared by the width-converting FIFO.
//   calc_w / calc_n / calc_r : storage width W, narrow width N and ratio R = W/N
//   calc_mode                : which conversion path is needed (equal/upsize/downsize)
//   count_width              : width of the occupancy counter, $clog2(depth)+1
//   ratio_ok / depth_ok /
//   thresh_ok / config_ok    : legality checks used by elaboration assertions
package fifo_pkg;

  typedef enum logic [1:0] {
    MODE_EQUAL    = 2'd0,
    MODE_UPSIZE   = 2'd1,
    MODE_DOWNSIZE = 2'd2
  } conv_mode_e;

  function automatic int calc_w(input int din_w, input int dout_w);
    return (din_w > dout_w) ? din_w : dout_w;
  endfunction

  function automatic int calc_n(input int din_w, input int dout_w);
    return (din_w < dout_w) ? din_w : dout_w;
  endfunction

  function automatic int calc_r(input int din_w, input int dout_w);
    return calc_w(din_w, dout_w) / calc_n(din_w, dout_w);
  endfunction

  function automatic conv_mode_e calc_mode(input int din_w, input int dout_w);
    if (din_w < dout_w) return MODE_UPSIZE;
    if (din_w > dout_w) return MODE_DOWNSIZE;
    return MODE_EQUAL;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Wide side must be an exact power-of-2 multiple of the narrow side.
  function automatic bit ratio_ok(input int din_w, input int dout_w);
    int w;
    int n;
    w = calc_w(din_w, dout_w);
    n = calc_n(din_w, dout_w);
    if (n < 1) return 1'b0;
    if ((w % n) != 0) return 1'b0;
    return is_pow2(w / n);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  function automatic bit thresh_ok(input int depth, input int thresh);
    return (thresh >= 1) && (thresh <= depth);
  endfunction

  function automatic bit config_ok(input int din_w, input int dout_w,
                                   input int depth, input int thresh);
    return ratio_ok(din_w, dout_w) && depth_ok(depth) && thresh_ok(depth, thresh);
  endfunction

endpackage

// File: rtl/sync_width_conv_fifo_if.sv
// sync_width_conv_fifo_if: write/read handshake and status bundle of the
// width-converting FIFO.
//   master modport : producer/consumer side (drives wr_en, din, rd_en)
//   slave modport  : the FIFO itself (drives dout and all status flags)
//   data_count is $clog2(DEPTH)+1 bits wide so that DEPTH itself fits.
interface sync_width_conv_fifo_if #(
  parameter int DIN_WIDTH  = 288,
  parameter int DOUT_WIDTH = 144,
  parameter int DEPTH      = 512
);
  import fifo_pkg::*;

  localparam int CW = count_width(DEPTH);

  logic                  wr_en;
  logic [DIN_WIDTH-1:0]  din;
  logic                  rd_en;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  full;
  logic                  prog_full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;
  logic [CW-1:0]         data_count;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, prog_full, empty, overflow, underflow, data_count
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, prog_full, empty, overflow, underflow, data_count
  );

endinterface

// File: rtl/sync_sdp_ram.sv
// sync_sdp_ram: simple dual-port RAM, WIDTH x DEPTH, one write port and one
// synchronous read port, written so that tools map it onto block RAM.
//   clk   : single clock
//   rst   : synchronous reset of the read data register only (array untouched)
//   we    : write enable, waddr / wdata : write address and data
//   re    : read enable, raddr : read address
//   rdata : registered read data, holds its value while re=0
module sync_sdp_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the FIFO output stage, so it also gets
  // the synchronous reset to present dout=0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_width_conv_fifo.sv
// sync_width_conv_fifo: single-clock width-converting FIFO with
// first-word-fall-through output.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset, discards all contents
//   bus  : slave side of sync_width_conv_fifo_if
//          wr_en/din        write request and data (DIN_WIDTH)
//          rd_en            acknowledge of the current dout
//          dout             head word (DOUT_WIDTH), valid while empty=0
//          full/prog_full   occupancy == DEPTH / >= PROG_FULL_THRESH
//          empty            no word in the output stage
//          overflow/underflow  one-cycle pulse after a rejected request
//          data_count       committed entries not yet fully read
// Storage entries are W = max(DIN_WIDTH, DOUT_WIDTH) bits. Upsizing packs
// narrow writes MSB-first into a pack register, downsizing unpacks the head
// entry MSB-first. The RAM read register is the output stage; it is
// refilled whenever it is empty or being popped, giving one word per clock.
module sync_width_conv_fifo
  import fifo_pkg::*;
#(
  parameter int DIN_WIDTH        = 288,
  parameter int DOUT_WIDTH       = 144,
  parameter int DEPTH            = 512,
  parameter int PROG_FULL_THRESH = DEPTH - 16
) (
  input logic                   clk,
  input logic                   rst,
  sync_width_conv_fifo_if.slave bus
);

  localparam int         W    = calc_w(DIN_WIDTH, DOUT_WIDTH);
  localparam int         N    = calc_n(DIN_WIDTH, DOUT_WIDTH);
  localparam int         R    = calc_r(DIN_WIDTH, DOUT_WIDTH);
  localparam conv_mode_e MODE = calc_mode(DIN_WIDTH, DOUT_WIDTH);
  localparam int         AW   = $clog2(DEPTH);
  localparam int         CW   = count_width(DEPTH);

  if (!ratio_ok(DIN_WIDTH, DOUT_WIDTH)) begin : g_bad_ratio
    $error("sync_width_conv_fifo: widths must differ by a power-of-2 ratio");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_width_conv_fifo: DEPTH must be a power of 2 and >= 4");
  end
  if (!thresh_ok(DEPTH, PROG_FULL_THRESH)) begin : g_bad_thresh
    $error("sync_width_conv_fifo: PROG_FULL_THRESH must be in 1..DEPTH");
  end

  genvar gi;

  // Pointer, count and output-stage state
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] data_count_reg, data_count_next;
  logic [CW-1:0] mem_count_reg, mem_count_next;  // entries in RAM, not yet in output stage
  logic          out_valid_reg, out_valid_next;
  logic          overflow_reg, underflow_reg;

  logic          full;
  logic          wr_acc;
  logic          rd_acc;
  logic          commit;   // a complete W-bit entry is written to RAM
  logic          pop;      // the output-stage entry is fully consumed
  logic          load;     // RAM read into the output stage
  logic [W-1:0]  wr_data;
  logic [W-1:0]  head;

  assign full   = (data_count_reg == CW'(DEPTH));
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & out_valid_reg;
  assign load   = (mem_count_reg != '0) & (~out_valid_reg | pop);

  // Write side: pack narrow words when upsizing, otherwise pass through.
  if (MODE == MODE_UPSIZE) begin : g_pack
    localparam int PW = $clog2(R);

    logic [PW-1:0]  pack_idx_reg;
    // Holds the first R-1 words of a group; the last word goes straight
    // from din into the committed entry.
    logic [W-N-1:0] pack_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        pack_idx_reg <= '0;
        pack_reg     <= '0;
      end else if (wr_acc) begin
        pack_idx_reg <= pack_idx_reg + 1'b1;
        for (int k = 0; k < R - 1; k++) begin
          if (pack_idx_reg == PW'(k)) begin
            pack_reg[W-N-1-k*N -: N] <= bus.din;
          end
        end
      end
    end

    assign commit  = wr_acc & (pack_idx_reg == PW'(R - 1));
    assign wr_data = {pack_reg, bus.din};
  end else begin : g_no_pack
    assign commit  = wr_acc;
    assign wr_data = bus.din;
  end

  // Read side: unpack the head entry MSB-first when downsizing.
  if (MODE == MODE_DOWNSIZE) begin : g_unpack
    localparam int SW = $clog2(R);

    logic [SW-1:0] sel_reg;
    logic [N-1:0]  rd_slice [R];

    for (gi = 0; gi < R; gi++) begin : g_slice
      assign rd_slice[gi] = head[W-1-gi*N -: N];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sel_reg <= '0;
      end else if (rd_acc) begin
        sel_reg <= sel_reg + 1'b1;
      end
    end

    assign pop      = rd_acc & (sel_reg == SW'(R - 1));
    assign bus.dout = rd_slice[sel_reg];
  end else begin : g_no_unpack
    assign pop      = rd_acc;
    assign bus.dout = head;
  end

  sync_sdp_ram #(
    .WIDTH      (W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr (wr_ptr_reg),
    .wdata (wr_data),
    .re    (load),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    data_count_next = data_count_reg;
    mem_count_next  = mem_count_reg;
    out_valid_next  = load | (out_valid_reg & ~pop);

    if (commit) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (load) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({commit, pop})
      2'b10:   data_count_next = data_count_reg + 1'b1;
      2'b01:   data_count_next = data_count_reg - 1'b1;
      default: data_count_next = data_count_reg;
    endcase

    case ({commit, load})
      2'b10:   mem_count_next = mem_count_reg + 1'b1;
      2'b01:   mem_count_next = mem_count_reg - 1'b1;
      default: mem_count_next = mem_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      data_count_reg <= '0;
      mem_count_reg  <= '0;
      out_valid_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      data_count_reg <= data_count_next;
      mem_count_reg  <= mem_count_next;
      out_valid_reg  <= out_valid_next;
      overflow_reg   <= bus.wr_en & full;
      underflow_reg  <= bus.rd_en & ~out_valid_reg;
    end
  end

  assign bus.full       = full;
  assign bus.prog_full  = (data_count_reg >= CW'(PROG_FULL_THRESH));
  assign bus.empty      = ~out_valid_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.underflow  = underflow_reg;
  assign bus.data_count = data_count_reg;

endmodule

// File: tb/tb_sync_width_conv_fifo.sv
module tb_sync_width_conv_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_dn, rst_up, rst_eq;
  int errors = 0;
  int checks = 0;

  sync_width_conv_fifo_if #(.DIN_WIDTH(8), .DOUT_WIDTH(4), .DEPTH(4)) dn_if ();
  sync_width_conv_fifo_if #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .DEPTH(4)) up_if ();
  sync_width_conv_fifo_if #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .DEPTH(4)) eq_if ();

  sync_width_conv_fifo #(.DIN_WIDTH(8), .DOUT_WIDTH(4), .DEPTH(4), .PROG_FULL_THRESH(4))
    u_dn (.clk(clk), .rst(rst_dn), .bus(dn_if));
  sync_width_conv_fifo #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .DEPTH(4), .PROG_FULL_THRESH(4))
    u_up (.clk(clk), .rst(rst_up), .bus(up_if));
  sync_width_conv_fifo #(.DIN_WIDTH(8), .DOUT_WIDTH(8), .DEPTH(4), .PROG_FULL_THRESH(3))
    u_eq (.clk(clk), .rst(rst_eq), .bus(eq_if));

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (eq_if.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", eq_if.empty); end
    checks++; if (eq_if.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", eq_if.full); end
    checks++; if (eq_if.prog_full !== 1'b0) begin errors++; $display("FAIL rst_prog_full: got %b expected 0", eq_if.prog_full); end
    checks++; if (eq_if.data_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", eq_if.data_count); end
    checks++; if (eq_if.dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h expected 00", eq_if.dout); end
    checks++; if ({eq_if.overflow, eq_if.underflow} !== 2'b00) begin errors++; $display("FAIL rst_ovf_unf: got %b expected 00", {eq_if.overflow, eq_if.underflow}); end
    checks++; if ({dn_if.empty, up_if.empty} !== 2'b11) begin errors++; $display("FAIL rst_empty_dn_up: got %b expected 11", {dn_if.empty, up_if.empty}); end
    rst_dn = 1'b0; rst_up = 1'b0; rst_eq = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_downsize();
    @(negedge clk); dn_if.din = 8'hAB; dn_if.wr_en = 1'b1;
    @(negedge clk); dn_if.wr_en = 1'b0;
    checks++; if (dn_if.empty !== 1'b1) begin errors++; $display("FAIL dn_latency_empty: got %b expected 1", dn_if.empty); end
    @(negedge clk);
    checks++; if (dn_if.empty !== 1'b0) begin errors++; $display("FAIL dn_first_empty: got %b expected 0", dn_if.empty); end
    checks++; if (dn_if.dout !== 4'hA) begin errors++; $display("FAIL dn_first_dout: got %h expected a", dn_if.dout); end
    checks++; if (dn_if.data_count !== 3'd1) begin errors++; $display("FAIL dn_count1: got %0d expected 1", dn_if.data_count); end
    dn_if.rd_en = 1'b1;
    @(negedge clk);
    checks++; if (dn_if.dout !== 4'hB) begin errors++; $display("FAIL dn_second_dout: got %h expected b", dn_if.dout); end
    @(negedge clk); dn_if.rd_en = 1'b0;
    checks++; if (dn_if.empty !== 1'b1) begin errors++; $display("FAIL dn_drained_empty: got %b expected 1", dn_if.empty); end
    checks++; if (dn_if.data_count !== 3'd0) begin errors++; $display("FAIL dn_drained_count: got %0d expected 0", dn_if.data_count); end
    $display("test_downsize done: wrote ab, read a,b");
  endtask

  task automatic test_upsize();
    @(negedge clk); up_if.din = 4'h1; up_if.wr_en = 1'b1;
    @(negedge clk);
    checks++; if (up_if.empty !== 1'b1) begin errors++; $display("FAIL up_partial_empty: got %b expected 1", up_if.empty); end
    checks++; if (up_if.data_count !== 3'd0) begin errors++; $display("FAIL up_partial_count: got %0d expected 0", up_if.data_count); end
    up_if.din = 4'h2;
    @(negedge clk); up_if.wr_en = 1'b0;
    checks++; if (up_if.data_count !== 3'd1) begin errors++; $display("FAIL up_commit_count: got %0d expected 1", up_if.data_count); end
    @(negedge clk);
    checks++; if (up_if.empty !== 1'b0) begin errors++; $display("FAIL up_valid_empty: got %b expected 0", up_if.empty); end
    checks++; if (up_if.dout !== 8'h12) begin errors++; $display("FAIL up_dout: got %h expected 12", up_if.dout); end
    up_if.rd_en = 1'b1;
    @(negedge clk); up_if.rd_en = 1'b0;
    checks++; if (up_if.empty !== 1'b1) begin errors++; $display("FAIL up_drained_empty: got %b expected 1", up_if.empty); end
    $display("test_upsize done: wrote 1,2, read 12");
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); eq_if.din = 8'(i); eq_if.wr_en = 1'b1;
    end
    @(negedge clk);
    checks++; if (eq_if.full !== 1'b1) begin errors++; $display("FAIL eq_full: got %b expected 1", eq_if.full); end
    eq_if.din = 8'h04;
    @(negedge clk); eq_if.wr_en = 1'b0;
    checks++; if (eq_if.overflow !== 1'b1) begin errors++; $display("FAIL eq_overflow_pulse: got %b expected 1", eq_if.overflow); end
    checks++; if (eq_if.data_count !== 3'd4) begin errors++; $display("FAIL eq_count_full: got %0d expected 4", eq_if.data_count); end
    @(negedge clk);
    checks++; if (eq_if.overflow !== 1'b0) begin errors++; $display("FAIL eq_overflow_clear: got %b expected 0", eq_if.overflow); end
    eq_if.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(i);
      checks++; if (eq_if.dout !== exp) begin errors++; $display("FAIL eq_read_order: got %h expected %h", eq_if.dout, exp); end
      @(negedge clk);
    end
    checks++; if (eq_if.empty !== 1'b1) begin errors++; $display("FAIL eq_empty_after_4: got %b expected 1", eq_if.empty); end
    @(negedge clk); eq_if.rd_en = 1'b0;
    checks++; if (eq_if.underflow !== 1'b1) begin errors++; $display("FAIL eq_underflow_pulse: got %b expected 1", eq_if.underflow); end
    @(negedge clk);
    checks++; if (eq_if.underflow !== 1'b0) begin errors++; $display("FAIL eq_underflow_clear: got %b expected 0", eq_if.underflow); end
    $display("test_overflow_underflow done: 5 writes, 4 reads, 1 extra read");
  endtask

  task automatic test_hold_count();
    logic [7:0] exp;
    @(negedge clk); eq_if.din = 8'hA0; eq_if.wr_en = 1'b1;
    @(negedge clk); eq_if.din = 8'hA1;
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      exp = 8'(8'hA0 + j);
      checks++; if (eq_if.data_count !== 3'd2) begin errors++; $display("FAIL hold_count: got %0d expected 2", eq_if.data_count); end
      checks++; if (eq_if.dout !== exp) begin errors++; $display("FAIL hold_dout: got %h expected %h", eq_if.dout, exp); end
      eq_if.din = 8'(8'hA2 + j); eq_if.wr_en = 1'b1; eq_if.rd_en = 1'b1;
      @(negedge clk);
    end
    eq_if.wr_en = 1'b0;
    checks++; if (eq_if.dout !== 8'hAA) begin errors++; $display("FAIL hold_drain0: got %h expected aa", eq_if.dout); end
    @(negedge clk);
    checks++; if (eq_if.dout !== 8'hAB) begin errors++; $display("FAIL hold_drain1: got %h expected ab", eq_if.dout); end
    @(negedge clk); eq_if.rd_en = 1'b0;
    checks++; if (eq_if.empty !== 1'b1) begin errors++; $display("FAIL hold_drained: got %b expected 1", eq_if.empty); end
    $display("test_hold_count done: 10 cycles of simultaneous read/write");
  endtask

  task automatic test_stream_wrap();
    int wcnt = 0;
    int rcnt = 0;
    int cyc = 0;
    logic [7:0] exp;
    while (rcnt < 16 && cyc < 200) begin
      @(negedge clk);
      eq_if.wr_en = 1'b0; eq_if.rd_en = 1'b0;
      if (eq_if.empty === 1'b0) begin
        exp = 8'(rcnt);
        checks++; if (eq_if.dout !== exp) begin errors++; $display("FAIL stream_order: got %h expected %h", eq_if.dout, exp); end
        eq_if.rd_en = 1'b1;
        rcnt++;
      end
      if (wcnt < 16 && eq_if.full === 1'b0) begin
        eq_if.din = 8'(wcnt); eq_if.wr_en = 1'b1;
        wcnt++;
      end
      cyc++;
    end
    @(negedge clk); eq_if.wr_en = 1'b0; eq_if.rd_en = 1'b0;
    checks++; if (rcnt != 16) begin errors++; $display("FAIL stream_timeout: got %0d words expected 16", rcnt); end
    checks++; if (eq_if.empty !== 1'b1) begin errors++; $display("FAIL stream_end_empty: got %b expected 1", eq_if.empty); end
    $display("test_stream_wrap done: %0d words in %0d cycles", rcnt, cyc);
  endtask

  task automatic test_prog_full();
    @(negedge clk); eq_if.din = 8'h10; eq_if.wr_en = 1'b1;
    @(negedge clk); eq_if.din = 8'h11;
    checks++; if (eq_if.prog_full !== 1'b0) begin errors++; $display("FAIL pf_at1: got %b expected 0", eq_if.prog_full); end
    @(negedge clk); eq_if.din = 8'h12;
    checks++; if (eq_if.prog_full !== 1'b0) begin errors++; $display("FAIL pf_at2: got %b expected 0", eq_if.prog_full); end
    @(negedge clk); eq_if.wr_en = 1'b0;
    checks++; if (eq_if.prog_full !== 1'b1) begin errors++; $display("FAIL pf_at3: got %b expected 1", eq_if.prog_full); end
    eq_if.rd_en = 1'b1;
    @(negedge clk); eq_if.rd_en = 1'b0;
    checks++; if (eq_if.prog_full !== 1'b0) begin errors++; $display("FAIL pf_fall: got %b expected 0", eq_if.prog_full); end
    checks++; if (eq_if.data_count !== 3'd2) begin errors++; $display("FAIL pf_count: got %0d expected 2", eq_if.data_count); end
    eq_if.rd_en = 1'b1;
    repeat (2) @(negedge clk);
    eq_if.rd_en = 1'b0;
    $display("test_prog_full done: threshold 3");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'hA; exp_seq[1] = 4'hB; exp_seq[2] = 4'hC; exp_seq[3] = 4'hD;
    @(negedge clk); dn_if.din = 8'hAB; dn_if.wr_en = 1'b1;
    @(negedge clk); dn_if.din = 8'hCD;
    @(negedge clk); dn_if.wr_en = 1'b0; dn_if.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dn_if.empty !== 1'b0 || dn_if.dout !== exp_seq[i]) begin errors++; $display("FAIL b2b_dout: got %h (empty %b) expected %h", dn_if.dout, dn_if.empty, exp_seq[i]); end
      @(negedge clk);
    end
    dn_if.rd_en = 1'b0;
    checks++; if (dn_if.empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b expected 1", dn_if.empty); end
    $display("test_back_to_back done: a,b,c,d on consecutive cycles");
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] seq [5];
    seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h5; seq[3] = 4'h6; seq[4] = 4'h7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); up_if.din = seq[i]; up_if.wr_en = 1'b1;
    end
    @(negedge clk); up_if.wr_en = 1'b0;
    checks++; if (up_if.data_count !== 3'd2) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 2", up_if.data_count); end
    rst_up = 1'b1;
    @(negedge clk); rst_up = 1'b0;
    checks++; if ({up_if.empty, up_if.full, up_if.prog_full, up_if.overflow, up_if.underflow} !== 5'b10000) begin errors++; $display("FAIL rmid_flags: got %b expected 10000", {up_if.empty, up_if.full, up_if.prog_full, up_if.overflow, up_if.underflow}); end
    checks++; if (up_if.data_count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", up_if.data_count); end
    checks++; if (up_if.dout !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h expected 00", up_if.dout); end
    @(negedge clk); up_if.din = 4'h3; up_if.wr_en = 1'b1;
    @(negedge clk); up_if.din = 4'h4;
    @(negedge clk); up_if.wr_en = 1'b0;
    @(negedge clk);
    checks++; if (up_if.dout !== 8'h34 || up_if.empty !== 1'b0) begin errors++; $display("FAIL rmid_fresh_dout: got %h (empty %b) expected 34", up_if.dout, up_if.empty); end
    checks++; if (up_if.data_count !== 3'd1) begin errors++; $display("FAIL rmid_fresh_count: got %0d expected 1", up_if.data_count); end
    $display("test_reset_mid_op done: reset discarded 2 entries and partial 7");
  endtask

  initial begin
    rst_dn = 1'b1; rst_up = 1'b1; rst_eq = 1'b1;
    dn_if.wr_en = 1'b0; dn_if.rd_en = 1'b0; dn_if.din = '0;
    up_if.wr_en = 1'b0; up_if.rd_en = 1'b0; up_if.din = '0;
    eq_if.wr_en = 1'b0; eq_if.rd_en = 1'b0; eq_if.din = '0;
    test_reset();
    test_downsize();
    test_upsize();
    test_overflow_underflow();
    test_hold_count();
    test_stream_wrap();
    test_prog_full();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_width_conv_fifo.md
# sync_width_conv_fifo

Single-clock, parametrised width-converting FIFO with first-word-fall-through (FWFT) output. It supports upsizing, downsizing and equal-width modes at any power-of-2 ratio, with configurable depth and prog_full threshold. It also reports occupancy and flags overflow/underflow, which the fixed-ratio async FIFO wrappers do not. It sits in datapaths that change bus width inside one clock domain, e.g. the packet-generator replay path, 288↔144.

## Interface
- DIN_WIDTH, 288: write data width.
- DOUT_WIDTH, 144: read data width.
- DEPTH, 512: storage entries, each W = max(DIN_WIDTH, DOUT_WIDTH) bits; power of 2, ≥ 4.
- PROG_FULL_THRESH, DEPTH-16: prog_full asserts when data_count ≥ this value; legal range 1..DEPTH.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DIN_WIDTH  write data.
- rd_en  in  1  read/acknowledge of the current dout (FWFT).
- dout  out  DOUT_WIDTH  head word, valid while empty=0.
- full  out  1  write would be rejected.
- prog_full  out  1  occupancy at or above the threshold.
- empty  out  1  no complete output word available.
- overflow  out  1  one-cycle pulse after a rejected write.
- underflow  out  1  one-cycle pulse after a rejected read.
- data_count  out  $clog2(DEPTH)+1  committed W-bit entries not yet fully read, including the entry in the output stage.

## Operation
- N = min width, R = W/N. Elaboration $error if W%N≠0, R is not a power of 2, DEPTH is not a power of 2, or PROG_FULL_THRESH is out of range.
- Accepted write: wr_en & !full. Accepted read: rd_en & !empty. Rejected requests have no effect beyond the error pulse.
- Upsize (DIN<DOUT), MSB-first packing:
  - The k-th accepted input word of a group goes to slice [W-1-k·N -: N] of a pack register; pack_idx counts 0..R-1.
  - The write with pack_idx=R-1 commits {pack, din} to memory on that same edge.
  - A partial group is invisible to the read side and is not counted.
- Downsize (DIN>DOUT), MSB-first unpacking:
  - dout = head[W-1-sel·N -: N], where sel counts 0..R-1.
  - A read advances sel. The read at sel=R-1 pops the entry and returns sel to 0.
- Equal widths: R=1; both degenerate paths vanish.
- full = (data_count == DEPTH). This holds even while the pack register is partially filled; there is no look-ahead, so a write at full is rejected even if a read occurs on the same edge.
- empty = no entry in the output stage. A read at empty is rejected even if a commit occurs on the same edge.
- Simultaneous commit and pop: data_count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; ordering is preserved across the wrap.
- overflow/underflow are registered: 1 for exactly the cycle after the offending request.

## Timing
- Reset values: dout=0, empty=1, full=0, prog_full=0, overflow=0, underflow=0, data_count=0; pointers, pack_idx and sel = 0; any partial pack is discarded.
- rst dominates wr_en/rd_en on the same edge. Reset mid-operation discards all contents with no drain.
- First-word latency: a commit into an empty FIFO at edge k gives empty=0 with valid dout after edge k+1.
- Memory is synchronous-read; the output stage prefetches the next entry so that back-to-back reads sustain one output word per clock.
- full, prog_full and data_count reflect the state after each edge; there are no combinational paths from wr_en/rd_en.
- Throughput: 1 write and 1 read per clock sustained in all modes.

## Structure
- Shared package fifo_pkg:
  - function for W, N and R from the two widths;
  - the $clog2-based count width;
  - the legality check used by the elaboration assertions.
- Sub-module sync_sdp_ram: simple dual-port W×DEPTH, one write port, one synchronous read port, no reset on the array; it infers BRAM.
- The top level holds the pack/unpack logic, pointers, count, output prefetch stage and flags.

## Test plan
The bench uses small parameters.
- Downsize, DIN=8, DOUT=4, DEPTH=4: write 0xAB at edge k → empty=0 after k+1, dout=0xA; read → 0xB; read → empty=1, data_count=0.
- Upsize, DIN=4, DOUT=8: write 0x1 → empty stays 1, data_count=0; write 0x2 → dout=0x12 one edge later, data_count=1.
- Equal widths 8/8, DEPTH=4:
  - write 0..4 back-to-back → full after the 4th write, 5th dropped, overflow=1 for one cycle;
  - reads return 0,1,2,3, then a further read gives underflow=1 for one cycle.
- Same configuration, PROG_FULL_THRESH=3:
  - hold data_count=2 with simultaneous read/write for 10 cycles → count stays 2;
  - stream 0..15 through the FIFO → output order exact across pointer wraps;
  - prog_full rises at the 3rd entry and falls at 2.
- Downsize, back-to-back reads of 2 entries (0xAB, 0xCD) → dout 0xA,0xB,0xC,0xD on consecutive cycles with no bubbles.
- Upsize reset mid-operation:
  - with 2 entries committed and a partial pack of 0x7, pulse rst → all flags at reset values;
  - then write 0x3, 0x4 → dout=0x34, with no stale nibble.
